// File: rtl/tristate_bus_pkg.sv
// Shared types and defaults for the tri-state bus arbiter slice.
// Holds the FSM state encoding and the owner-index width helper.
package tristate_bus_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        OWN  = 2'd1,
        TURN = 2'd2
    } state_t;

    localparam int DEF_N        = 4;
    localparam int DEF_W        = 8;
    localparam int DEF_MAX_HOLD = 16;
    localparam int DEF_TURN_CYC = 1;

    // Width of an index into n requesters; never narrower than one bit.
    function automatic int idx_w(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/rr_pick.sv
// Purpose: round-robin pick of the first set request at or above ptr, wrapping N-1 -> 0.
// Latency: purely combinational, zero cycles.
// Backpressure: none; found=0 when no request is set.
module rr_pick
    import tristate_bus_pkg::*;
#(
    parameter int N  = DEF_N,
    parameter int IW = idx_w(N)
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    output logic          found,
    output logic [IW-1:0] idx
);

    always_comb begin
        found = 1'b0;
        idx   = '0;
        for (int i = 0; i < N; i++) begin
            if (!found && req[IW'((int'(ptr) + i) % N)]) begin
                found = 1'b1;
                idx   = IW'((int'(ptr) + i) % N);
            end
        end
    end

endmodule

// File: rtl/tristate_bus_arbiter.sv
// Purpose: round-robin owner sequencing for one shared tri-state bus with turnaround and hold timeout.
// Latency: grant one edge after a request is sampled in IDLE; bus follows the registered owner combinationally.
// Backpressure: requesters hold i_req until granted; ownership ends on drop of i_req or after MAX_HOLD cycles.
module tristate_bus_arbiter
    import tristate_bus_pkg::*;
#(
    parameter int N        = DEF_N,
    parameter int W        = DEF_W,
    parameter int MAX_HOLD = DEF_MAX_HOLD,
    parameter int TURN_CYC = DEF_TURN_CYC
) (
    input  logic                   i_clk,
    input  logic                   i_rst_n,
    input  logic [N-1:0]           i_req,
    input  logic [N*W-1:0]         i_data,
    output logic [N-1:0]           o_gnt,
    output logic [N-1:0]           o_drv_en,
    output logic [idx_w(N)-1:0]    o_owner,
    output logic                   o_busy,
    output logic                   o_timeout,
    output logic [W-1:0]           o_bus
);

    localparam int IW = idx_w(N);
    localparam int CW = $clog2(MAX_HOLD) + 1;
    localparam int TW = $clog2(TURN_CYC) + 1;

    state_t        state;
    logic [IW-1:0] ptr;
    logic [IW-1:0] pick_idx;
    logic [IW-1:0] nxt_ptr;
    logic          pick_found;
    logic [CW-1:0] hold_cnt;
    logic [TW-1:0] turn_cnt;
    logic [W-1:0]  owner_dat;

    rr_pick #(
        .N  (N),
        .IW (IW)
    ) u_pick (
        .req   (i_req),
        .ptr   (ptr),
        .found (pick_found),
        .idx   (pick_idx)
    );

    always_comb begin
        nxt_ptr = (pick_idx == IW'(N - 1)) ? '0 : pick_idx + 1'b1;
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state     <= IDLE;
            ptr       <= '0;
            hold_cnt  <= '0;
            turn_cnt  <= '0;
            o_gnt     <= '0;
            o_owner   <= '0;
            o_busy    <= 1'b0;
            o_timeout <= 1'b0;
        end else begin
            o_timeout <= 1'b0;
            case (state)
                IDLE: begin
                    if (pick_found) begin
                        state    <= OWN;
                        o_gnt    <= N'(1) << pick_idx;
                        o_owner  <= pick_idx;
                        o_busy   <= 1'b1;
                        hold_cnt <= '0;
                        ptr      <= nxt_ptr;
                    end
                end
                OWN: begin
                    // Other requesters never preempt; only the owner's own drop or the hold limit ends it.
                    if (!i_req[o_owner] || hold_cnt == CW'(MAX_HOLD - 1)) begin
                        state     <= TURN;
                        o_gnt     <= '0;
                        o_busy    <= 1'b0;
                        turn_cnt  <= '0;
                        o_timeout <= i_req[o_owner];
                    end else if (hold_cnt != '1) begin
                        hold_cnt <= hold_cnt + 1'b1;
                    end
                end
                TURN: begin
                    if (turn_cnt == TW'(TURN_CYC - 1)) begin
                        state <= IDLE;
                    end else begin
                        turn_cnt <= turn_cnt + 1'b1;
                    end
                end
                default: begin
                    state  <= IDLE;
                    o_gnt  <= '0;
                    o_busy <= 1'b0;
                end
            endcase
        end
    end

    assign o_drv_en = o_gnt;

    always_comb begin
        owner_dat = '0;
        for (int k = 0; k < N; k++) begin
            if (o_owner == IW'(k)) begin
                owner_dat = i_data[k*W +: W];
            end
        end
    end

    // Busy is a register, so the bus releases to z the instant reset clears it.
    assign o_bus = o_busy ? owner_dat : {W{1'bz}};

endmodule

// File: tb/tb_tristate_bus_arbiter.sv
// Bench for tristate_bus_arbiter: directed table and corner sequences on one instance,
// randomized traffic against an abstract ownership model on a second instance.
module tb_tristate_bus_arbiter;

    localparam int N     = 4;
    localparam int W     = 8;
    localparam int HOLD1 = 16;
    localparam int TURN1 = 1;
    localparam int HOLD2 = 6;
    localparam int TURN2 = 2;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic           rst1_n, rst2_n;
    logic [N-1:0]   req1, req2;
    logic [N*W-1:0] data1, data2;
    logic [N-1:0]   gnt1, drv1, gnt2, drv2;
    logic [1:0]     own1, own2;
    logic           busy1, busy2, to1, to2;
    wire  [W-1:0]   bus1, bus2;

    int checks   = 0;
    int failures = 0;

    tristate_bus_arbiter #(.N(N), .W(W), .MAX_HOLD(HOLD1), .TURN_CYC(TURN1)) dut1 (
        .i_clk(clk), .i_rst_n(rst1_n), .i_req(req1), .i_data(data1),
        .o_gnt(gnt1), .o_drv_en(drv1), .o_owner(own1), .o_busy(busy1),
        .o_timeout(to1), .o_bus(bus1)
    );

    tristate_bus_arbiter #(.N(N), .W(W), .MAX_HOLD(HOLD2), .TURN_CYC(TURN2)) dut2 (
        .i_clk(clk), .i_rst_n(rst2_n), .i_req(req2), .i_data(data2),
        .o_gnt(gnt2), .o_drv_en(drv2), .o_owner(own2), .o_busy(busy2),
        .o_timeout(to2), .o_bus(bus2)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [W-1:0] slice_of(input logic [N*W-1:0] d, input int k);
        return d[k*W +: W];
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // At most one driver, and drive enables mirror grants, on every cycle including reset.
    always @(negedge clk) begin
        check("onehot_dut1", 32'($countones(drv1) <= 1), 32'd1);
        check("onehot_dut2", 32'($countones(drv2) <= 1), 32'd1);
        check("drv_eq_gnt1", 32'(drv1), 32'(gnt1));
        check("drv_eq_gnt2", 32'(drv2), 32'(gnt2));
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    typedef struct {
        logic [N-1:0] req;
        logic [N-1:0] gnt;
        int           owner;
        logic         to;
    } vec_t;

    vec_t tbl[25];

    // Abstract model: who owns, how many cycles so far, z-cycles still owed, next start point.
    int   m_owner, m_held, m_turn, m_ptr;
    logic m_to;

    task automatic model_edge(input logic [N-1:0] r);
        m_to = 1'b0;
        if (m_owner >= 0) begin
            if (!r[m_owner] || m_held == HOLD2) begin
                m_to    = r[m_owner];
                m_owner = -1;
                m_turn  = TURN2;
            end else begin
                m_held++;
            end
        end else if (m_turn > 0) begin
            m_turn--;
        end else begin
            for (int i = 0; i < N; i++) begin
                if (m_owner < 0 && r[(m_ptr + i) % N]) begin
                    m_owner = (m_ptr + i) % N;
                    m_held  = 1;
                end
            end
            if (m_owner >= 0) m_ptr = (m_owner + 1) % N;
        end
    endtask

    initial begin
        logic [N-1:0] eg;
        int  run;
        int  zrun;
        logic seen, prev_busy;

        tbl[0]  = '{4'b1111, 4'b0001,  0, 1'b0};
        tbl[1]  = '{4'b1111, 4'b0001,  0, 1'b0};
        tbl[2]  = '{4'b1111, 4'b0001,  0, 1'b0};
        tbl[3]  = '{4'b1110, 4'b0000, -1, 1'b0};
        tbl[4]  = '{4'b1110, 4'b0000, -1, 1'b0};
        tbl[5]  = '{4'b1110, 4'b0010,  1, 1'b0};
        tbl[6]  = '{4'b1100, 4'b0000, -1, 1'b0};
        tbl[7]  = '{4'b1100, 4'b0000, -1, 1'b0};
        tbl[8]  = '{4'b1101, 4'b0100,  2, 1'b0};
        tbl[9]  = '{4'b1001, 4'b0000, -1, 1'b0};
        tbl[10] = '{4'b1001, 4'b0000, -1, 1'b0};
        tbl[11] = '{4'b1001, 4'b1000,  3, 1'b0};
        tbl[12] = '{4'b0001, 4'b0000, -1, 1'b0};
        tbl[13] = '{4'b0001, 4'b0000, -1, 1'b0};
        tbl[14] = '{4'b0001, 4'b0001,  0, 1'b0};
        tbl[15] = '{4'b0100, 4'b0000, -1, 1'b0};
        tbl[16] = '{4'b0100, 4'b0000, -1, 1'b0};
        tbl[17] = '{4'b0100, 4'b0100,  2, 1'b0};
        tbl[18] = '{4'b0101, 4'b0100,  2, 1'b0};
        tbl[19] = '{4'b0001, 4'b0000, -1, 1'b0};
        tbl[20] = '{4'b0101, 4'b0000, -1, 1'b0};
        tbl[21] = '{4'b0101, 4'b0001,  0, 1'b0};
        tbl[22] = '{4'b0100, 4'b0000, -1, 1'b0};
        tbl[23] = '{4'b0101, 4'b0000, -1, 1'b0};
        tbl[24] = '{4'b0101, 4'b0100,  2, 1'b0};

        rst1_n = 1'b0;
        rst2_n = 1'b0;
        req1   = 4'b1111;
        req2   = '0;
        data1  = {8'h44, 8'h33, 8'h22, 8'h11};
        data2  = '0;

        // Reset held with all requesting: nothing may be granted.
        repeat (3) tick();
        check("rst_gnt", 32'(gnt1), 32'd0);
        check("rst_busy", 32'(busy1), 32'd0);
        check("rst_owner", 32'(own1), 32'd0);
        check("rst_timeout", 32'(to1), 32'd0);
        rst1_n = 1'b1;
        #1;
        check("post_rst_gnt", 32'(gnt1), 32'd0);
        check("post_rst_busy", 32'(busy1), 32'd0);

        for (int i = 0; i < 25; i++) begin
            req1 = tbl[i].req;
            tick();
            check($sformatf("tbl%0d_gnt", i), 32'(gnt1), 32'(tbl[i].gnt));
            check($sformatf("tbl%0d_busy", i), 32'(busy1), 32'(tbl[i].owner >= 0));
            check($sformatf("tbl%0d_timeout", i), 32'(to1), 32'(tbl[i].to));
            if (tbl[i].owner >= 0) begin
                check($sformatf("tbl%0d_owner", i), 32'(own1), 32'(tbl[i].owner));
                check($sformatf("tbl%0d_bus", i), 32'(bus1), 32'(slice_of(data1, tbl[i].owner)));
            end
        end

        // Hold timeout: lone requester 2 never drops.
        rst1_n = 1'b0;
        #1;
        rst1_n = 1'b1;
        req1 = 4'b0100;
        tick();
        check("to_first_gnt", 32'(gnt1), 32'b0100);
        run = 1;
        for (int g = 0; g < 40; g++) begin
            tick();
            if (gnt1 != 4'b0100) break;
            run++;
        end
        check("to_hold_cycles", 32'(run), 32'(HOLD1));
        check("to_pulse", 32'(to1), 32'd1);
        check("to_busy", 32'(busy1), 32'd0);
        check("to_drv", 32'(drv1), 32'd0);
        tick();
        check("to_pulse_end", 32'(to1), 32'd0);
        check("to_gap_gnt", 32'(gnt1), 32'd0);
        tick();
        check("to_regrant", 32'(gnt1), 32'b0100);
        check("to_regrant_bus", 32'(bus1), 32'(slice_of(data1, 2)));

        // Request pulse that rises and falls between edges is not seen.
        rst1_n = 1'b0;
        #1;
        rst1_n = 1'b1;
        req1 = 4'b0001;
        #2;
        req1 = 4'b0000;
        tick();
        check("pulse_ignored", 32'(gnt1), 32'd0);

        // Async reset mid-ownership, then pointer restarts at 0.
        req1 = 4'b0010;
        tick();
        check("mid_gnt", 32'(gnt1), 32'b0010);
        #3;
        rst1_n = 1'b0;
        #1;
        check("async_drv", 32'(drv1), 32'd0);
        check("async_busy", 32'(busy1), 32'd0);
        #2;
        rst1_n = 1'b1;
        req1 = 4'b1010;
        tick();
        check("after_rst_winner", 32'(gnt1), 32'b0010);
        check("after_rst_owner", 32'(own1), 32'd1);

        // Randomized traffic on the TURN_CYC=2 instance.
        req1 = '0;
        rst2_n = 1'b1;
        m_owner = -1; m_held = 0; m_turn = 0; m_ptr = 0; m_to = 1'b0;
        zrun = 0; seen = 1'b0; prev_busy = 1'b0;
        for (int c = 0; c < 10000; c++) begin
            for (int k = 0; k < N; k++) begin
                if (req2[k]) begin
                    if ($urandom_range(0, 9) == 0) req2[k] = 1'b0;
                end else if ($urandom_range(0, 3) == 0) begin
                    req2[k] = 1'b1;
                end
            end
            data2 = {$urandom};
            @(posedge clk);
            model_edge(req2);
            #1;
            eg = (m_owner >= 0) ? (4'b0001 << m_owner) : 4'b0000;
            check("rnd_gnt", 32'(gnt2), 32'(eg));
            check("rnd_busy", 32'(busy2), 32'(m_owner >= 0));
            check("rnd_timeout", 32'(to2), 32'(m_to));
            if (m_owner >= 0) begin
                check("rnd_owner", 32'(own2), 32'(m_owner));
                check("rnd_bus", 32'(bus2), 32'(slice_of(data2, m_owner)));
            end
            if (busy2) begin
                check("rnd_bus_known", 32'($isunknown(bus2)), 32'd0);
                if (!prev_busy && seen) check("rnd_gap", 32'(zrun >= TURN2 + 1), 32'd1);
                seen = 1'b1;
                zrun = 0;
            end else begin
                zrun++;
            end
            prev_busy = busy2;
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
